// File: rtl/change_monitor.sv
// change_monitor: hardware twin of a $changed check on signal `a`.
// Samples `a` on enabled posedges and emits registered changed/rose/fell
// pulses. It also tracks how long `a` has stayed unchanged, flags a stall
// after MAX_STABLE unchanged samples, and counts changes with saturation.
//
// Ports:
//   clk        system clock, all sampling on posedge
//   rst_n      asynchronous active-low reset
//   en         sample enable (sample ignored when low)
//   clr        synchronous clear of counters and sticky stall flag
//   a          monitored signal [WIDTH-1:0]
//   changed    pulse: last enabled sample differs from the previous one
//   rose       pulse: any bit went 0->1 between those samples
//   fell       pulse: any bit went 1->0 between those samples
//   stalled    high while in the stall state
//   stall_seen sticky: stall entered since reset or clr
//   change_cnt saturating count of changes [CNT_W-1:0]
//   stable_cnt saturating count of consecutive unchanged samples [CNT_W-1:0]
module change_monitor #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned MAX_STABLE = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    output logic             changed,
    output logic             rose,
    output logic             fell,
    output logic             stalled,
    output logic             stall_seen,
    output logic [CNT_W-1:0] change_cnt,
    output logic [CNT_W-1:0] stable_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] STALL_AT = CNT_W'(MAX_STABLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_prev, a_prev_nxt;
    logic             changed_nxt, rose_nxt, fell_nxt, stalled_nxt, seen_nxt;
    logic [CNT_W-1:0] change_cnt_nxt, stable_cnt_nxt;
    logic             chg;

    // Difference against the previously accepted sample (reset value 0).
    assign chg = (a != a_prev);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_prev     <= '0;
            changed    <= 1'b0;
            rose       <= 1'b0;
            fell       <= 1'b0;
            stalled    <= 1'b0;
            stall_seen <= 1'b0;
            change_cnt <= '0;
            stable_cnt <= '0;
        end else begin
            state      <= state_nxt;
            a_prev     <= a_prev_nxt;
            changed    <= changed_nxt;
            rose       <= rose_nxt;
            fell       <= fell_nxt;
            stalled    <= stalled_nxt;
            stall_seen <= seen_nxt;
            change_cnt <= change_cnt_nxt;
            stable_cnt <= stable_cnt_nxt;
        end
    end

    // Next-state, counter and pulse logic.
    always_comb begin
        state_nxt      = state;
        a_prev_nxt     = a_prev;
        changed_nxt    = 1'b0;
        rose_nxt       = 1'b0;
        fell_nxt       = 1'b0;
        seen_nxt       = stall_seen;
        change_cnt_nxt = change_cnt;
        stable_cnt_nxt = stable_cnt;

        if (en) begin
            a_prev_nxt  = a;
            changed_nxt = chg;
            rose_nxt    = |(a & ~a_prev);
            fell_nxt    = |(~a & a_prev);
            if (chg) begin
                if (change_cnt != CNT_MAX) begin
                    change_cnt_nxt = change_cnt + CNT_W'(1);
                end
                stable_cnt_nxt = '0;
            end else if (stable_cnt != CNT_MAX) begin
                stable_cnt_nxt = stable_cnt + CNT_W'(1);
            end
        end

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = TRACK;
                end
            end
            TRACK: begin
                // A clear in the same cycle wins over entering the stall.
                if (en && !clr && (stable_cnt_nxt == STALL_AT)) begin
                    state_nxt = STALL;
                    seen_nxt  = 1'b1;
                end
            end
            STALL: begin
                if (en && chg) begin
                    state_nxt = TRACK;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Clear overrides counter updates; pulses and a_prev are unaffected.
        if (clr) begin
            change_cnt_nxt = '0;
            stable_cnt_nxt = '0;
            seen_nxt       = 1'b0;
            if (state_nxt == STALL) begin
                state_nxt = TRACK;
            end
        end

        stalled_nxt = (state_nxt == STALL);
    end

endmodule

// File: doc/change_monitor.md
Name: change_monitor

Overview:
- Synthesizable RTL twin of the `$changed` check, placed directly downstream of the stimulus signal `a`.
- Samples `a` on every `clk` posedge and registers changed/rose/fell pulses.
- Tracks consecutive-stable runs with a small FSM and flags a stall when `a` stays unchanged for MAX_STABLE samples.
- Keeps a saturating change counter, so the bench compares assertion results against hardware-observable status.

Parameters:
- WIDTH, 1, width of monitored signal `a`.
- MAX_STABLE, 3, consecutive unchanged samples that trigger stall (legal range ≥ 1).
- CNT_W, 8, width of change counter and stable-run counter.

Ports:
- clk  input  1  system clock; all sampling on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; when low, the sample is ignored.
- clr  input  1  synchronous clear of counters and sticky stall flag.
- a  input  WIDTH  monitored signal; upstream drives it on negedge, so it is stable at posedge.
- changed  output  1  registered pulse: last enabled sample differs from the previous one.
- rose  output  1  registered pulse: any bit went 0→1 between those samples.
- fell  output  1  registered pulse: any bit went 1→0 between those samples.
- stalled  output  1  high while the FSM is in STALL.
- stall_seen  output  1  sticky: STALL has been entered since reset or clr.
- change_cnt  output  CNT_W  saturating count of changed pulses.
- stable_cnt  output  CNT_W  current consecutive-unchanged sample count, saturating.

Behaviour:
- Reset values (async, rst_n low): a_prev=0, changed=rose=fell=0, stalled=0, stall_seen=0, change_cnt=0, stable_cnt=0, FSM=IDLE.
- a_prev reset to 0 mirrors the `$changed` default-past-value rule: the first enabled sample of `a`≠0 after reset reports changed=1.
- Sample event = posedge with en=1. At each sample event: chg = (a != a_prev); a_prev <= a.
- Pulse timing: changed/rose/fell reflect chg (rise = a & ~a_prev, fall = ~a & a_prev, OR-reduced). They are visible one cycle after the sampling edge and last exactly one cycle.
- Posedge with en=0: pulses go to 0; a_prev, counters and FSM hold.
- change_cnt: +1 per sample with chg=1; saturates at 2^CNT_W−1, no wrap.
- stable_cnt: reset to 0 on a sample with chg=1; otherwise +1, saturating at 2^CNT_W−1.
- FSM states and transitions:
  - IDLE → TRACK on the first sample event; counters update normally on that same sample.
  - TRACK → STALL on the sample where the next stable_cnt value equals MAX_STABLE.
  - STALL → TRACK on a sample with chg=1.
  - Any state → IDLE only via reset.
- stalled=1 exactly while in STALL. stall_seen is set on the TRACK→STALL transition and cleared only by clr or reset.
- clr=1 at posedge: change_cnt=0, stable_cnt=0, stall_seen=0, FSM→TRACK if not IDLE. a_prev still updates if en=1, and pulses still report chg. clr has priority over the counter increments in the same cycle.
- Reset mid-run: all state clears immediately (async). The first enabled sample after deassertion compares against 0.
- Simultaneous events:
  - chg=1 in STALL: exit to TRACK, stable_cnt=0, change_cnt+1, all in the same cycle.
  - clr with chg: counters end at 0, and the pulse is still emitted.
- WIDTH>1: rose and fell may both be 1 in the same cycle.

Test Plan:
- Reset, en=1, a=0,1,0,1 on successive negedges → changed=1 every cycle from the 2nd sample on (1st sample 0 vs 0 → 0); rose/fell alternate; change_cnt=3 after 4 samples; stalled=0.
- a held at 1 for 5 samples after one 0→1 → stable_cnt 1,2,3 over the next samples; stalled and stall_seen go high on the 3rd stable sample (MAX_STABLE=3); a→0 then gives stalled=0 next cycle, fell=1, stall_seen stays 1.
- en=0 for 4 cycles while a toggles, then en=1 with a equal to the last enabled value → no pulses; counters and stable_cnt unchanged; the next sample reports changed=0.
- CNT_W=3 with toggling `a` every sample for 10 samples → change_cnt saturates at 7 and stays at 7.
- clr pulse in STALL with a toggling that cycle → change_cnt=0, stable_cnt=0, stall_seen=0, FSM=TRACK, changed=1 next cycle.
- rst_n low mid-stall for 3 ns (asynchronous, between edges) → all outputs 0 immediately; after release, first sample a=1 gives changed=1 and rose=1.
